// File: rtl/cache_mem_pkg.sv
// Shared types and defaults for the cache backing-memory responder.
package cache_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT     = 2'd1,
      ST_RD_BURST = 2'd2,
      ST_WR_BURST = 2'd3
   } state_t;

   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_LATENCY    = 3;
   localparam int DEF_MEM_WORDS  = 1024;
   localparam int DEF_OFF_W      = $clog2(DEF_LINE_WORDS);
   localparam int DEF_WORD_W     = $clog2(DEF_MEM_WORDS);

   // Width of the latency down-counter; it only ever holds LATENCY-1.
   function automatic int lat_cnt_w(input int lat);
      return (lat > 2) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port RAM: synchronous write, synchronous (registered) read.
module mem_sp_ram #(
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 1024,
   parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [MEM_WORDS];
   logic [DATA_W-1:0] r_rdata;

   // Storage array: never reset, so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   // Read register: holds its value while i_re is low; cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n)    r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_line_mem.sv
// Line-granular backing memory: accepts read/write line requests, returns
// read lines as word-serial bursts after a fixed latency, sinks write lines.
//
// Handshakes: every channel transfers on the rising edge where valid and ready
// are both high. The requester holds req_* stable while req_valid is high and
// req_ready is low; rsp_data/rsp_last are held stable while rsp_valid is high
// and rsp_ready is low. wready is high for the whole write burst.
module cache_line_mem
   import cache_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int MEM_WORDS  = DEF_MEM_WORDS,
   parameter int LATENCY    = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              wvalid,
   output logic              wready,
   input  logic [DATA_W-1:0] wdata,
   output logic              wr_done,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic [1:0]        o_dbg_state
);

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int WORD_W = $clog2(MEM_WORDS);
   localparam int LINE_W = WORD_W - OFF_W;
   localparam int LAT_W  = lat_cnt_w(LATENCY);

   localparam logic [OFF_W-1:0] BEAT_ONE    = OFF_W'(1);
   localparam logic [OFF_W-1:0] BEAT_LAST   = OFF_W'(LINE_WORDS - 1);
   localparam logic [OFF_W-1:0] BEAT_PENULT = OFF_W'(LINE_WORDS - 2);
   localparam logic [LAT_W-1:0] LAT_ONE     = LAT_W'(1);
   localparam logic [LAT_W-1:0] LAT_LOAD    = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t            r_state;
   logic              r_req_ready;
   logic              r_wready;
   logic              r_wr_done;
   logic              r_rsp_valid;
   logic              r_rsp_last;
   logic [OFF_W-1:0]  r_beat;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic [LINE_W-1:0] r_base;

   logic              w_ram_we;
   logic              w_ram_re;
   logic [OFF_W-1:0]  w_word_sel;
   logic [WORD_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_rdata;
   logic [LINE_W-1:0] w_req_line;
   logic              w_unused;

   // Line index of the request: word offset and out-of-range upper bits dropped.
   assign w_req_line = req_addr[WORD_W+1 : OFF_W+2];
   assign w_unused   = ^{req_addr[ADDR_W-1 : WORD_W+2], req_addr[OFF_W+1 : 0]};

   // Writes use the current beat; reads fetch one beat ahead of rsp_data
   // because the RAM read port is registered.
   assign w_word_sel = (r_state == ST_WR_BURST) ? r_beat :
                       (r_rsp_valid ? r_beat + BEAT_ONE : '0);
   assign w_ram_addr = {r_base, w_word_sel};
   assign w_ram_we   = rst_n && (r_state == ST_WR_BURST) && wvalid;
   assign w_ram_re   = (r_state == ST_RD_BURST) &&
                       (!r_rsp_valid || (rsp_ready && !r_rsp_last));

   mem_sp_ram #(
      .DATA_W    (DATA_W),
      .MEM_WORDS (MEM_WORDS)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (wdata),
      .o_rdata (w_ram_rdata)
   );

   // Control FSM: request acceptance, latency wait, read and write bursts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b1;
         r_wready    <= 1'b0;
         r_wr_done   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_beat      <= '0;
         r_lat_cnt   <= '0;
         r_base      <= '0;
      end else begin
         r_wr_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_base      <= w_req_line;
                  r_beat      <= '0;
                  r_req_ready <= 1'b0;
                  if (req_write) begin
                     r_state  <= ST_WR_BURST;
                     r_wready <= 1'b1;
                  end else if (LATENCY == 0) begin
                     r_state <= ST_RD_BURST;
                  end else begin
                     r_state   <= ST_WAIT;
                     r_lat_cnt <= LAT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (r_lat_cnt == '0) r_state   <= ST_RD_BURST;
               else                 r_lat_cnt <= r_lat_cnt - LAT_ONE;
            end
            ST_RD_BURST: begin
               if (!r_rsp_valid) begin
                  // First cycle: beat 0 is being fetched, it appears next edge.
                  r_rsp_valid <= 1'b1;
                  r_rsp_last  <= 1'b0;
               end else if (rsp_ready) begin
                  if (r_rsp_last) begin
                     r_state     <= ST_IDLE;
                     r_rsp_valid <= 1'b0;
                     r_rsp_last  <= 1'b0;
                     r_req_ready <= 1'b1;
                     r_beat      <= '0;
                  end else begin
                     r_beat     <= r_beat + BEAT_ONE;
                     r_rsp_last <= (r_beat == BEAT_PENULT);
                  end
               end
            end
            ST_WR_BURST: begin
               if (wvalid) begin
                  if (r_beat == BEAT_LAST) begin
                     r_state     <= ST_IDLE;
                     r_wready    <= 1'b0;
                     r_wr_done   <= 1'b1;
                     r_req_ready <= 1'b1;
                     r_beat      <= '0;
                  end else begin
                     r_beat <= r_beat + BEAT_ONE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign wready      = r_wready;
   assign wr_done     = r_wr_done;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_last    = r_rsp_last;
   assign rsp_data    = w_ram_rdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_line_mem.sv
// Bench for cache_line_mem: cycle-level behavioural model plus directed and
// randomized line traffic.
module tb_cache_line_mem;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int MEM_WORDS  = 1024;
   localparam int LATENCY    = 3;

   // ---------------- clock / reset / DUT ----------------
   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr  = '0;
   logic              wvalid    = 1'b0;
   logic [DATA_W-1:0] wdata     = '0;
   logic              rsp_ready = 1'b0;
   logic              req_ready, wready, wr_done, rsp_valid, rsp_last;
   logic [DATA_W-1:0] rsp_data;
   logic [1:0]        dbg_state;

   always #5 clk = ~clk;

   cache_line_mem #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS),
      .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wr_done(wr_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .o_dbg_state(dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Transaction view: idle / reading / writing, acceptance cycle, beats done.
   logic [DATA_W-1:0] mem_m [MEM_WORDS];
   int m_busy  = 0;   // 0 idle, 1 read, 2 write
   int m_acc   = 0;
   int m_line  = 0;
   int m_taken = 0;
   int m_done  = -10;
   bit chk_en  = 1'b0;

   function automatic int line_of(input logic [31:0] a);
      return int'(((a >> 2) % MEM_WORDS) & ~(LINE_WORDS - 1));
   endfunction

   function automatic bit exp_rsp_valid();
      return (m_busy == 1) && (cyc >= m_acc + LATENCY + 1);
   endfunction

   always @(posedge clk) begin
      bit v;
      v = exp_rsp_valid();
      if (!rst_n) begin
         m_busy  = 0;
         m_taken = 0;
         m_done  = -10;
      end else begin
         case (m_busy)
            0: if (req_valid) begin
               m_busy  = req_write ? 2 : 1;
               m_acc   = cyc + 1;
               m_line  = line_of(req_addr);
               m_taken = 0;
            end
            1: if (v && rsp_ready) begin
               m_taken++;
               if (m_taken == LINE_WORDS) m_busy = 0;
            end
            default: if (wvalid) begin
               mem_m[m_line + m_taken] = wdata;
               m_taken++;
               if (m_taken == LINE_WORDS) begin
                  m_busy = 0;
                  m_done = cyc + 1;
               end
            end
         endcase
      end
      cyc++;
      chk_en = 1'b1;
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         bit v;
         v = exp_rsp_valid();
         check("req_ready", 32'(req_ready), 32'(m_busy == 0));
         check("wready",    32'(wready),    32'(m_busy == 2));
         check("wr_done",   32'(wr_done),   32'(m_done == cyc));
         check("rsp_valid", 32'(rsp_valid), 32'(v));
         if (v) begin
            check("rsp_data", rsp_data, mem_m[m_line + m_taken]);
            check("rsp_last", 32'(rsp_last), 32'(m_taken == LINE_WORDS - 1));
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] got_q[$];

   task automatic push4(input logic [31:0] a, b, c, d);
      exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
   endtask

   task automatic compare_burst(input string name);
      check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      foreach (got_q[i]) begin
         if (exp_q.size() > 0) check(name, got_q[i], exp_q.pop_front());
      end
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input bit wr, input logic [31:0] a, output int acc_cyc);
      bit acc;
      acc       = 1'b0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
         tick();
      end
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom();
      acc_cyc   = cyc;
      n_tests++;
      if (!acc) begin
         n_fail++;
         $display("FAIL req_accept: got no req_ready within 100 cycles, required acceptance");
      end
   endtask

   task automatic write_beats(input logic [31:0] d [LINE_WORDS], input bit gaps);
      for (int k = 0; k < LINE_WORDS; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               wvalid = 1'b0;
               wdata  = $urandom();
               tick();
            end
         end
         wvalid = 1'b1;
         wdata  = d[k];
         tick();
      end
      wvalid = 1'b0;
   endtask

   task automatic write_line(input logic [31:0] a, input logic [31:0] d [LINE_WORDS], input bit gaps);
      int acc;
      send_req(1'b1, a, acc);
      write_beats(d, gaps);
      @(negedge clk);
      check("wr_done_after_last_beat", 32'(wr_done), 32'd1);
      tick();
   endtask

   // Collect up to max_beats; optionally stall on one beat, or randomize
   // rsp_ready and drive stray write beats that must be ignored.
   task automatic collect_burst(input int max_beats, input int stall_beat, input int stall_n,
                                input logic [31:0] stall_exp, input bit rnd, output int first_cyc);
      int  taken, stalls, budget;
      bit  done, stalling;
      taken = 0; stalls = 0; budget = 0; done = 1'b0;
      first_cyc = -1;
      got_q.delete();
      while (!done && budget < 200) begin
         stalling = (taken == stall_beat) && (stalls < stall_n);
         if (stalling)  rsp_ready = 1'b0;
         else if (rnd)  rsp_ready = ($urandom_range(0, 3) != 0);
         else           rsp_ready = 1'b1;
         if (rnd) begin
            wvalid = 1'($urandom_range(0, 1));
            wdata  = $urandom();
         end
         @(negedge clk);
         if (rsp_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (stalling) begin
               stalls++;
               check("stall_hold_data", rsp_data, stall_exp);
            end
            if (rsp_ready) begin
               got_q.push_back(rsp_data);
               taken++;
               if (rsp_last || taken == max_beats) done = 1'b1;
            end
         end
         tick();
         budget++;
      end
      rsp_ready = 1'b0;
      wvalid    = 1'b0;
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL burst_timeout: got %0d beats, required %0d", taken, max_beats);
      end
   endtask

   task automatic rand_txn();
      int line, acc, first;
      logic [31:0] a;
      logic [31:0] d [LINE_WORDS];
      line = $urandom_range(0, 15);
      a = ($urandom() << 12) | 32'(line << 4) | 32'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 1) == 1) begin
         for (int k = 0; k < LINE_WORDS; k++) d[k] = $urandom();
         write_line(a, d, 1'b1);
      end else begin
         for (int k = 0; k < LINE_WORDS; k++) exp_q.push_back(mem_m[line * LINE_WORDS + k]);
         send_req(1'b0, a, acc);
         collect_burst(LINE_WORDS, -1, 0, 32'd0, 1'b1, first);
         check("rand_rd_latency", 32'(first - acc), 32'(LATENCY + 1));
         compare_burst("rand_rd_data");
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int acc, first;
      logic [31:0] d [LINE_WORDS];

      for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = '0;

      // Reset values.
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_wready",    32'(wready),    32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_wr_done",   32'(wr_done),   32'd0);
      check("rst_rsp_last",  32'(rsp_last),  32'd0);
      check("rst_rsp_data",  rsp_data,       32'd0);
      check("rst_state",     32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      tick();

      // Preload lines 0..15 so every later read targets written storage.
      for (int l = 0; l < 16; l++) begin
         for (int k = 0; k < LINE_WORDS; k++) d[k] = $urandom();
         write_line(32'(l * 16), d, 1'b1);
      end

      // Write 0x200 back-to-back, then read it back.
      d[0] = 32'hDEADBEEF; d[1] = 32'd1; d[2] = 32'd2; d[3] = 32'd3;
      write_line(32'h200, d, 1'b0);
      check("model_pin_0x200", mem_m[32'h80], 32'hDEADBEEF);
      send_req(1'b0, 32'h200, acc);
      collect_burst(LINE_WORDS, -1, 0, 32'd0, 1'b0, first);
      check("rd_latency", 32'(first - acc), 32'd4);
      push4(32'hDEADBEEF, 32'd1, 32'd2, 32'd3);
      compare_burst("rd_0x200");

      // Stall two cycles on beat 2.
      send_req(1'b0, 32'h200, acc);
      collect_burst(LINE_WORDS, 1, 2, 32'd1, 1'b0, first);
      push4(32'hDEADBEEF, 32'd1, 32'd2, 32'd3);
      compare_burst("rd_stall");

      // Offset ignored and MEM_WORDS aliasing.
      send_req(1'b0, 32'h20C, acc);
      collect_burst(LINE_WORDS, -1, 0, 32'd0, 1'b0, first);
      push4(32'hDEADBEEF, 32'd1, 32'd2, 32'd3);
      compare_burst("rd_0x20C");
      send_req(1'b0, 32'h1200, acc);
      collect_burst(LINE_WORDS, -1, 0, 32'd0, 1'b0, first);
      push4(32'hDEADBEEF, 32'd1, 32'd2, 32'd3);
      compare_burst("rd_0x1200");

      // Reset pulse after beat 2 of a read.
      send_req(1'b0, 32'h200, acc);
      collect_burst(2, -1, 0, 32'd0, 1'b0, first);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'd1);
      compare_burst("rd_partial");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      tick();
      send_req(1'b0, 32'h200, acc);
      collect_burst(LINE_WORDS, -1, 0, 32'd0, 1'b0, first);
      push4(32'hDEADBEEF, 32'd1, 32'd2, 32'd3);
      compare_burst("rd_after_rst");

      // Read request held while a write burst runs.
      send_req(1'b1, 32'h200, acc);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h200;
      for (int k = 0; k < LINE_WORDS; k++) begin
         wvalid = 1'b1;
         wdata  = 32'(10 + k);
         @(negedge clk);
         check("held_req_ready_busy", 32'(req_ready), 32'd0);
         tick();
      end
      wvalid = 1'b0;
      @(negedge clk);
      check("held_wr_done", 32'(wr_done), 32'd1);
      check("held_req_ready_done", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      acc = cyc;
      collect_burst(LINE_WORDS, -1, 0, 32'd0, 1'b0, first);
      check("held_rd_latency", 32'(first - acc), 32'd4);
      push4(32'd10, 32'd11, 32'd12, 32'd13);
      compare_burst("held_rd");

      // Randomized traffic.
      for (int t = 0; t < 40; t++) rand_txn();

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
